// File: rtl/spi_sram_pkg.sv
// Shared types and constants for the SPI serial-SRAM target.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_sram_pkg;

    localparam int         SPI_SRAM_ADDR_W = 16;
    localparam logic [7:0] CMD_READ        = 8'h03;
    localparam logic [7:0] CMD_WRITE       = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_READ    = 3'd4,
        ST_WRITE   = 3'd5,
        ST_IGNORE  = 3'd6
    } spi_sram_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises SPI pins into the core clock and derives sclk/cs edge pulses.
// Latency: SYNC_STAGES cycles from pin change to the edge pulse.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic mosi_sync,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic                   sclk_prev;
    logic                   cs_prev;

    // cs resets high so a released reset never looks like a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff   <= '0;
            mosi_ff   <= '0;
            cs_ff     <= '1;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk};
            mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], mosi};
            cs_ff     <= {cs_ff[SYNC_STAGES-2:0], cs};
            sclk_prev <= sclk_ff[SYNC_STAGES-1];
            cs_prev   <= cs_ff[SYNC_STAGES-1];
        end
    end

    assign mosi_sync = mosi_ff[SYNC_STAGES-1];
    assign sclk_rise =  sclk_ff[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_ff[SYNC_STAGES-1] &  sclk_prev;
    assign cs_fall   = ~cs_ff[SYNC_STAGES-1]   &  cs_prev;
    assign cs_rise   =  cs_ff[SYNC_STAGES-1]   & ~cs_prev;

endmodule

// File: rtl/spi_sram_slave.sv
// 23LC-style SPI READ/WRITE target driving a synchronous byte memory port.
// Latency: strobes issue ~SYNC_STAGES+1 cycles after the 8th sclk rise of a byte.
// Backpressure: none; memory must accept a strobe every cycle, rdata one cycle after re.
module spi_sram_slave #(
    parameter int         ADDR_W      = spi_sram_pkg::SPI_SRAM_ADDR_W,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_READ    = spi_sram_pkg::CMD_READ,
    parameter logic [7:0] CMD_WRITE   = spi_sram_pkg::CMD_WRITE
) (
    input  logic              clk_core_i,
    input  logic              rst_n_i,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    output logic              busy_o,
    output logic              cmd_err_o
);

    import spi_sram_pkg::*;

    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk       (clk_core_i),
        .rst_n     (rst_n_i),
        .sclk      (spi_sclk_i),
        .cs        (spi_cs_i),
        .mosi      (spi_mosi_i),
        .mosi_sync (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    spi_sram_state_e   state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        rx_sr_q;
    logic [7:0]        tx_sr_q;
    logic [7:0]        addr_hi_q;
    logic [ADDR_W-1:0] addr_q;
    logic              is_read_q;
    logic              re_d_q;
    logic              miso_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [7:0]        wdata_q;
    logic              cmd_err_q;
    logic [7:0]        rx_next;

    assign rx_next = {rx_sr_q[6:0], mosi_s};

    always_ff @(posedge clk_core_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            rx_sr_q   <= 8'd0;
            tx_sr_q   <= 8'd0;
            addr_hi_q <= 8'd0;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            re_d_q    <= 1'b0;
            miso_q    <= 1'b0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            wdata_q   <= 8'd0;
            cmd_err_q <= 1'b0;
        end else begin
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            re_d_q    <= mem_re_q;

            // write address advances the cycle after its strobe
            if (mem_we_q) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (cs_rise) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= 3'd0;
                rx_sr_q   <= 8'd0;
            end else if (cs_fall && state_q == ST_IDLE) begin
                state_q   <= ST_CMD;
                bit_cnt_q <= 3'd0;
                rx_sr_q   <= 8'd0;
            end else if (sclk_rise && state_q != ST_IDLE) begin
                rx_sr_q   <= rx_next;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_q <= 3'd0;
                    case (state_q)
                        ST_CMD: begin
                            if (rx_next == CMD_READ || rx_next == CMD_WRITE) begin
                                is_read_q <= (rx_next == CMD_READ);
                                state_q   <= ST_ADDR_HI;
                            end else begin
                                state_q   <= ST_IGNORE;
                                cmd_err_q <= 1'b1;
                            end
                        end
                        ST_ADDR_HI: begin
                            addr_hi_q <= rx_next;
                            state_q   <= ST_ADDR_LO;
                        end
                        ST_ADDR_LO: begin
                            addr_q <= ADDR_W'({addr_hi_q, rx_next});
                            if (is_read_q) begin
                                mem_re_q <= 1'b1;
                                state_q  <= ST_READ;
                            end else begin
                                state_q  <= ST_WRITE;
                            end
                        end
                        ST_READ: begin
                            // prefetch the next byte while the master still clocks this one
                            addr_q   <= addr_q + ADDR_W'(1);
                            mem_re_q <= 1'b1;
                        end
                        ST_WRITE: begin
                            mem_we_q <= 1'b1;
                            wdata_q  <= rx_next;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            if (state_q != ST_READ || cs_rise) begin
                miso_q <= 1'b0;
            end else if (sclk_fall) begin
                miso_q  <= tx_sr_q[7];
                tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            end

            if (re_d_q) begin
                tx_sr_q <= mem_rdata_i;
            end
        end
    end

    assign spi_miso_o  = miso_q;
    assign mem_addr_o  = addr_q;
    assign mem_re_o    = mem_re_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign cmd_err_o   = cmd_err_q;

endmodule

// File: tb/tb_spi_sram_slave.sv
// Randomised SPI master + memory model with a strobe scoreboard for spi_sram_slave.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'd0;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        cmd_err;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    int tests = 0;
    int fails = 0;
    int err_seen = 0;
    int err_exp = 0;

    typedef struct packed {
        logic        is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } mem_ev_t;

    mem_ev_t exp_q[$];

    always #5 clk = ~clk;

    spi_sram_slave dut (
        .clk_core_i  (clk),
        .rst_n_i     (rst_n),
        .spi_sclk_i  (sclk),
        .spi_cs_i    (cs),
        .spi_mosi_i  (mosi),
        .spi_miso_o  (miso),
        .mem_addr_o  (mem_addr),
        .mem_re_o    (mem_re),
        .mem_rdata_i (mem_rdata),
        .mem_we_o    (mem_we),
        .mem_wdata_o (mem_wdata),
        .busy_o      (busy),
        .cmd_err_o   (cmd_err)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every memory strobe must match the next expected event
    always @(negedge clk) begin
        if (rst_n && (mem_re || mem_we)) begin
            mem_ev_t e;
            check("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got we=%0b re=%0b addr=0x%h, required no strobe",
                         mem_we, mem_re, mem_addr);
            end else begin
                e = exp_q.pop_front();
                check("strobe_is_write", {31'd0, mem_we}, {31'd0, e.is_wr});
                check("strobe_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                if (e.is_wr) check("strobe_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
            end
        end
        if (rst_n && cmd_err) err_seen++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_cyc(4);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
    endtask

    task automatic cs_high();
        int n;
        wait_cyc(4);
        cs = 1'b1;
        n = 0;
        while (busy && n < 3) begin
            wait_cyc(1);
            n++;
        end
        check("busy_drop_after_cs", {31'd0, busy}, 32'd0);
        wait_cyc(4);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_cyc(4);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            wait_cyc(4);
            sclk = 1'b0;
        end
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [15:0] addr);
        logic [7:0] rx;
        xfer_bits(cmd, 8, rx);
        check("miso_cmd_phase", {24'd0, rx}, 32'd0);
        xfer_bits(addr[15:8], 8, rx);
        check("miso_addr_hi_phase", {24'd0, rx}, 32'd0);
        xfer_bits(addr[7:0], 8, rx);
        check("miso_addr_lo_phase", {24'd0, rx}, 32'd0);
    endtask

    task automatic write_frame(input logic [15:0] addr, input logic [31:0] d, input int n);
        logic [7:0]  rx;
        logic [7:0]  b;
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 16'(i);
            b = d[31-8*i -: 8];
            ref_mem[a] = b;
            exp_q.push_back('{is_wr: 1'b1, addr: a, data: b});
        end
        cs_low();
        send_header(8'h02, addr);
        for (int i = 0; i < n; i++) begin
            xfer_bits(d[31-8*i -: 8], 8, rx);
            check("miso_write_phase", {24'd0, rx}, 32'd0);
        end
        cs_high();
    endtask

    task automatic read_frame(input logic [15:0] addr, input int n);
        logic [7:0]  rx;
        logic [15:0] a;
        for (int i = 0; i <= n; i++) begin
            a = addr + 16'(i);
            exp_q.push_back('{is_wr: 1'b0, addr: a, data: 8'd0});
        end
        cs_low();
        send_header(8'h03, addr);
        for (int i = 0; i < n; i++) begin
            a = addr + 16'(i);
            xfer_bits(8'h00, 8, rx);
            check("read_data", {24'd0, rx}, {24'd0, ref_mem[a]});
        end
        cs_high();
    endtask

    task automatic bad_frame(input logic [7:0] op);
        logic [7:0] rx;
        err_exp++;
        cs_low();
        send_header(op, 16'h0000);
        xfer_bits(8'hFF, 8, rx);
        check("miso_ignore_phase", {24'd0, rx}, 32'd0);
        cs_high();
        check("cmd_err_count", err_seen, err_exp);
    endtask

    // partial data byte then CS high; with_cs raises CS together with the 8th sclk rise
    task automatic abort_write(input logic [15:0] addr, input int nbits, input logic with_cs);
        logic [7:0] rx;
        logic [7:0] d;
        d = 8'($urandom);
        cs_low();
        send_header(8'h02, addr);
        if (with_cs) begin
            xfer_bits(d, 7, rx);
            mosi = d[0];
            wait_cyc(4);
            sclk = 1'b1;
            cs   = 1'b1;
            wait_cyc(8);
            check("busy_after_cs_with_rise", {31'd0, busy}, 32'd0);
            sclk = 1'b0;
            wait_cyc(4);
        end else begin
            xfer_bits(d, nbits, rx);
            cs_high();
        end
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rx;
        logic [15:0] a;
        logic [31:0] d;
        logic [7:0]  op;
        int          n;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        wait_cyc(3);
        check("reset_outputs", {27'd0, busy, miso, mem_re, mem_we, cmd_err}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(4);
        check("post_reset_outputs", {27'd0, busy, miso, mem_re, mem_we, cmd_err}, 32'd0);
        check("post_reset_addr", {16'd0, mem_addr}, 32'd0);

        write_frame(16'h0010, 32'hA500_0000, 1);
        write_frame(16'h0011, 32'h5AC3_0000, 2);
        read_frame(16'h0010, 3);

        write_frame(16'hFFFF, 32'h1122_0000, 2);
        read_frame(16'hFFFF, 2);

        bad_frame(8'h9F);

        abort_write(16'h0020, 5, 1'b0);
        read_frame(16'h0020, 1);
        abort_write(16'h0030, 7, 1'b1);
        read_frame(16'h0030, 1);

        // reset in the middle of a read data byte
        exp_q.push_back('{is_wr: 1'b0, addr: 16'h0010, data: 8'd0});
        cs_low();
        send_header(8'h03, 16'h0010);
        xfer_bits(8'h00, 3, rx);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_flags", {27'd0, busy, miso, mem_re, mem_we, cmd_err}, 32'd0);
        check("midframe_reset_addr", {16'd0, mem_addr}, 32'd0);
        check("midframe_reset_wdata", {24'd0, mem_wdata}, 32'd0);
        sclk = 1'b0;
        cs   = 1'b1;
        mosi = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(4);
        check("after_reset_idle", {31'd0, busy}, 32'd0);
        read_frame(16'h0010, 1);

        for (int k = 0; k < 24; k++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'hFFFD + 16'($urandom_range(0, 2));
            n = $urandom_range(1, 4);
            d = $urandom;
            case ($urandom_range(0, 5))
                0, 1: write_frame(a, d, n);
                2, 3: read_frame(a, n);
                4: begin
                    op = 8'($urandom);
                    if (op == 8'h02 || op == 8'h03) op = 8'hA5;
                    bad_frame(op);
                end
                default: begin
                    abort_write(a, $urandom_range(1, 7), 1'($urandom_range(0, 1)));
                    read_frame(a, 1);
                end
            endcase
        end

        wait_cyc(10);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("cmd_err_total", err_seen, err_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
